alu_ctrl_stage: RTL and testbench
=================================

// Module: alu_ctrl_stage
// PURPOSE
//  Drive side of the execute ALU: decodes a WISC-SP13 instruction into the ALU control bundle
//  (Op, Cin, operand inversion, B-select, extended immediate, set-condition) and registers it
//  as the ID/EX pipeline boundary. Holds on stall, bubbles on flush. Latches HALT and stops issue.
// PARAMETERS
//  WIDTH   16  datapath / immediate width
//  OPW     4   ALU Op width
// PORTS
//  clk        in   1      system clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  instr      in   16     instruction word from IF/ID
//  valid_in   in   1      instr is a real instruction
//  stall      in   1      hold all registered outputs this cycle
//  flush      in   1      replace next registered entry with a bubble
//  alu_op     out  OPW    ALU Op: 0000 ADD, 0001 OR, 0010 XOR, 0011 AND; 01ss shift (ss: 00 ROL,
//                         01 SLL, 10 ROR, 11 SRL); 1000 SLBI; 1001 BTR
//  inv_a      out  1      invert operand A before ALU
//  inv_b      out  1      invert operand B before ALU
//  alu_cin    out  1      ALU carry-in
//  bsel_imm   out  1      1: B = imm_ext, 0: B = Rt
//  imm_ext    out  WIDTH  extended immediate
//  set_cond   out  2      00 none/SEQ-cond per set_en, 01 SLT, 10 SLE, 11 SCO
//  set_en     out  1      result is a set-instruction flag
//  valid_out  out  1      registered bundle is a real instruction
//  halted     out  1      HALT has issued; sticky until rst
//  err        out  1      only with ALU_CTRL_ERR_EN (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: every output 0; FSM = RUN. Async assert, sync-free deassert on next clk edge.
//  - Latency: one cycle instr -> registered bundle. Decode itself is purely combinational.
//  - Update priority per edge: rst > flush > stall > load. flush with stall: bubble wins
//    (valid_out=0, other outputs 0). stall alone: all outputs hold. Otherwise load decode.
//  - valid_in=0 loads a bubble (all fields 0).
//  - Decode (opcode = instr[15:11], func = instr[1:0]):
//    ADDI 01000 op0000, imm sext5;  SUBI 01001 op0000 inv_a cin=1 imm sext5
//    XORI 01010 op0010 imm zext5;   ANDNI 01011 op0011 inv_b imm zext5
//    ROLI/SLLI/RORI/SRLI 101ss op01ss imm zext4; ST/LD/STU 10000/10001/10011 op0000 imm sext5
//    R-arith 11011: func 00 ADD, 01 SUB (inv_a,cin), 10 XOR, 11 ANDN (inv_b); bsel_imm=0
//    R-shift 11010: op01ss with ss=func; bsel_imm=0
//    SEQ/SLT/SLE 11100/11101/11110: op0000 inv_b cin=1 set_en, set_cond 00/01/10
//    SCO 11111: op0000 set_en set_cond=11;  BTR 11001 op1001
//    LBI 11000 op0000 imm sext8, inv_a=0 with A forced 0 downstream; SLBI 10010 op1000 imm zext8
//    Branch/jump/NOP/other: bubble-equivalent ALU fields (op0000, no inv), valid_out follows valid_in.
//  - FSM RUN -> HALTED when HALT (00000) loads with valid_in=1 and no stall/flush.
//    HALTED: halted=1, every subsequent load is a bubble; stall/flush still obeyed; exit only on rst.
//  - Flush of the HALT entry in the same edge it would load: no transition.
//  - rst mid-stall or in HALTED: immediate return to RUN with all outputs 0.
// CONFIGURATION
//  ALU_CTRL_ERR_EN defined: err rises the cycle after an unencoded opcode loads with
//  valid_in=1; sticky until rst; that entry issues as a bubble.
//  Undefined: err tied 0; unencoded opcodes treated as NOP.
// STRUCTURE
//  Package wisc_pkg: opcode localparams, ALU Op codes, set_cond codes, alu_ctrl_t bundle typedef.
//  Sub-module alu_ctrl_dec: combinational instr -> alu_ctrl_t; top holds register, FSM, stall/flush.
// TESTING
//  1 rst=1 any inputs -> all outputs 0; release, instr=ADDI imm -3 valid -> next cycle op0000
//    bsel_imm=1 imm_ext=16'hFFFD valid_out=1
//  2 SUB R (11011,func01) -> inv_a=1 alu_cin=1 bsel_imm=0; ANDNI imm 5'h1F -> inv_b=1 imm_ext=16'h001F
//  3 load SLLI imm 4 then stall=1 for 3 cycles with instr=XORI -> outputs stay op0101 imm 4
//  4 stall=1 and flush=1 same edge -> valid_out=0, all fields 0
//  5 HALT valid -> halted=1 next cycle; following ADD valid -> valid_out=0; rst -> halted=0
//  6 (ALU_CTRL_ERR_EN) unencoded opcode valid -> err=1 next cycle, valid_out=0, err sticky

Source files
------------

// File: rtl/wisc_pkg.sv
// WISC-SP13 encodings, ALU op/set-condition codes and the ALU control bundle shared by the
// ID/EX control stage and its decoder.
package wisc_pkg;

  localparam int DATA_W = 16;
  localparam int OP_W   = 4;

  // Major opcodes, instr[15:11]
  localparam logic [4:0] OPC_HALT  = 5'b00000;
  localparam logic [4:0] OPC_NOP   = 5'b00001;
  localparam logic [4:0] OPC_J     = 5'b00100;
  localparam logic [4:0] OPC_JR    = 5'b00101;
  localparam logic [4:0] OPC_JAL   = 5'b00110;
  localparam logic [4:0] OPC_JALR  = 5'b00111;
  localparam logic [4:0] OPC_ADDI  = 5'b01000;
  localparam logic [4:0] OPC_SUBI  = 5'b01001;
  localparam logic [4:0] OPC_XORI  = 5'b01010;
  localparam logic [4:0] OPC_ANDNI = 5'b01011;
  localparam logic [4:0] OPC_BEQZ  = 5'b01100;
  localparam logic [4:0] OPC_BNEZ  = 5'b01101;
  localparam logic [4:0] OPC_BLTZ  = 5'b01110;
  localparam logic [4:0] OPC_BGEZ  = 5'b01111;
  localparam logic [4:0] OPC_ST    = 5'b10000;
  localparam logic [4:0] OPC_LD    = 5'b10001;
  localparam logic [4:0] OPC_SLBI  = 5'b10010;
  localparam logic [4:0] OPC_STU   = 5'b10011;
  localparam logic [4:0] OPC_ROLI  = 5'b10100;
  localparam logic [4:0] OPC_SLLI  = 5'b10101;
  localparam logic [4:0] OPC_RORI  = 5'b10110;
  localparam logic [4:0] OPC_SRLI  = 5'b10111;
  localparam logic [4:0] OPC_LBI   = 5'b11000;
  localparam logic [4:0] OPC_BTR   = 5'b11001;
  localparam logic [4:0] OPC_RSHF  = 5'b11010;
  localparam logic [4:0] OPC_RARI  = 5'b11011;
  localparam logic [4:0] OPC_SEQ   = 5'b11100;
  localparam logic [4:0] OPC_SLT   = 5'b11101;
  localparam logic [4:0] OPC_SLE   = 5'b11110;
  localparam logic [4:0] OPC_SCO   = 5'b11111;

  localparam logic [OP_W-1:0] ALU_ADD  = 4'b0000;
  localparam logic [OP_W-1:0] ALU_XOR  = 4'b0010;
  localparam logic [OP_W-1:0] ALU_AND  = 4'b0011;
  localparam logic [OP_W-1:0] ALU_SLBI = 4'b1000;
  localparam logic [OP_W-1:0] ALU_BTR  = 4'b1001;
  localparam logic [1:0]      ALU_SHIFT_HI = 2'b01;

  localparam logic [1:0] SC_EQ = 2'b00;
  localparam logic [1:0] SC_LT = 2'b01;
  localparam logic [1:0] SC_LE = 2'b10;
  localparam logic [1:0] SC_CO = 2'b11;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic              inv_a;
    logic              inv_b;
    logic              cin;
    logic              bsel_imm;
    logic [DATA_W-1:0] imm_ext;
    logic [1:0]        set_cond;
    logic              set_en;
  } alu_ctrl_t;

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } stage_state_e;

  function automatic logic [DATA_W-1:0] sext5(input logic [4:0] v);
    return {{(DATA_W-5){v[4]}}, v};
  endfunction

  function automatic logic [DATA_W-1:0] sext8(input logic [7:0] v);
    return {{(DATA_W-8){v[7]}}, v};
  endfunction

endpackage

// File: rtl/alu_ctrl_stage_if.sv
// Instruction-in / ALU-control-out bus of the ID/EX control stage.
interface alu_ctrl_stage_if #(
  parameter int WIDTH = 16,
  parameter int OPW   = 4
);
  logic [15:0]      instr;
  logic             valid_in;
  logic             stall;
  logic             flush;
  logic [OPW-1:0]   alu_op;
  logic             inv_a;
  logic             inv_b;
  logic             alu_cin;
  logic             bsel_imm;
  logic [WIDTH-1:0] imm_ext;
  logic [1:0]       set_cond;
  logic             set_en;
  logic             valid_out;
  logic             halted;
  logic             err;

  modport master (
    output instr, valid_in, stall, flush,
    input  alu_op, inv_a, inv_b, alu_cin, bsel_imm, imm_ext, set_cond, set_en,
           valid_out, halted, err
  );

  modport slave (
    input  instr, valid_in, stall, flush,
    output alu_op, inv_a, inv_b, alu_cin, bsel_imm, imm_ext, set_cond, set_en,
           valid_out, halted, err
  );
endinterface

// File: rtl/alu_ctrl_dec.sv
// Combinational WISC-SP13 instruction -> ALU control bundle decoder.
// siic/rti (00010/00011) are not supported here and report as illegal.
module alu_ctrl_dec
  import wisc_pkg::*;
(
  input  logic [15:0] instr_i,
  output alu_ctrl_t   ctrl_o,
  output logic        halt_o,
  output logic        illegal_o
);

  logic [4:0] opc;
  logic [1:0] func;
  logic       unused_bits;

  assign opc         = instr_i[15:11];
  assign func        = instr_i[1:0];
  assign unused_bits = ^instr_i[10:8];

  always_comb begin
    ctrl_o    = '0;
    halt_o    = 1'b0;
    illegal_o = 1'b0;
    case (opc)
      OPC_HALT: halt_o = 1'b1;
      OPC_NOP, OPC_J, OPC_JR, OPC_JAL, OPC_JALR,
      OPC_BEQZ, OPC_BNEZ, OPC_BLTZ, OPC_BGEZ: begin
      end
      OPC_ADDI, OPC_ST, OPC_LD, OPC_STU: begin
        ctrl_o.bsel_imm = 1'b1;
        ctrl_o.imm_ext  = sext5(instr_i[4:0]);
      end
      OPC_SUBI: begin
        ctrl_o.inv_a    = 1'b1;
        ctrl_o.cin      = 1'b1;
        ctrl_o.bsel_imm = 1'b1;
        ctrl_o.imm_ext  = sext5(instr_i[4:0]);
      end
      OPC_XORI: begin
        ctrl_o.op       = ALU_XOR;
        ctrl_o.bsel_imm = 1'b1;
        ctrl_o.imm_ext  = {{(DATA_W-5){1'b0}}, instr_i[4:0]};
      end
      OPC_ANDNI: begin
        ctrl_o.op       = ALU_AND;
        ctrl_o.inv_b    = 1'b1;
        ctrl_o.bsel_imm = 1'b1;
        ctrl_o.imm_ext  = {{(DATA_W-5){1'b0}}, instr_i[4:0]};
      end
      OPC_ROLI, OPC_SLLI, OPC_RORI, OPC_SRLI: begin
        ctrl_o.op       = {ALU_SHIFT_HI, opc[1:0]};
        ctrl_o.bsel_imm = 1'b1;
        ctrl_o.imm_ext  = {{(DATA_W-4){1'b0}}, instr_i[3:0]};
      end
      OPC_RARI: begin
        case (func)
          2'b00: ctrl_o.op = ALU_ADD;
          2'b01: begin
            ctrl_o.inv_a = 1'b1;
            ctrl_o.cin   = 1'b1;
          end
          2'b10: ctrl_o.op = ALU_XOR;
          default: begin
            ctrl_o.op    = ALU_AND;
            ctrl_o.inv_b = 1'b1;
          end
        endcase
      end
      OPC_RSHF: ctrl_o.op = {ALU_SHIFT_HI, func};
      OPC_SEQ, OPC_SLT, OPC_SLE: begin
        ctrl_o.inv_b    = 1'b1;
        ctrl_o.cin      = 1'b1;
        ctrl_o.set_en   = 1'b1;
        ctrl_o.set_cond = (opc == OPC_SEQ) ? SC_EQ : (opc == OPC_SLT) ? SC_LT : SC_LE;
      end
      OPC_SCO: begin
        ctrl_o.set_en   = 1'b1;
        ctrl_o.set_cond = SC_CO;
      end
      OPC_BTR: ctrl_o.op = ALU_BTR;
      // LBI: A is forced to 0 downstream, so plain ADD of the immediate
      OPC_LBI: begin
        ctrl_o.bsel_imm = 1'b1;
        ctrl_o.imm_ext  = sext8(instr_i[7:0]);
      end
      OPC_SLBI: begin
        ctrl_o.op       = ALU_SLBI;
        ctrl_o.bsel_imm = 1'b1;
        ctrl_o.imm_ext  = {{(DATA_W-8){1'b0}}, instr_i[7:0]};
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_stage.sv
// ID/EX ALU control register: decode, stall/flush handling and sticky HALT.
// Optional sticky illegal-opcode flag on err when ALU_CTRL_ERR_EN is defined.
module alu_ctrl_stage
  import wisc_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             rst,
  alu_ctrl_stage_if.slave  bus
);

`ifdef ALU_CTRL_ERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  alu_ctrl_t    dec_ctrl;
  logic         dec_halt;
  logic         dec_illegal;

  alu_ctrl_t    ctrl_d, ctrl_q;
  logic         valid_d, valid_q;
  logic         halt_load, err_load;
  logic         live, kill;
  stage_state_e state_q;
  logic         err_q;

  alu_ctrl_dec u_dec (
    .instr_i   (bus.instr),
    .ctrl_o    (dec_ctrl),
    .halt_o    (dec_halt),
    .illegal_o (dec_illegal)
  );

  always_comb begin
    live      = bus.valid_in && (state_q == ST_RUN);
    kill      = ErrEn && dec_illegal;
    valid_d   = live && !kill;
    ctrl_d    = valid_d ? dec_ctrl : '0;
    halt_load = valid_d && dec_halt;
    err_load  = live && kill;
  end

  // Priority: rst > flush > stall > load; the FSM only advances on a real load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q  <= '0;
      valid_q <= 1'b0;
      state_q <= ST_RUN;
      err_q   <= 1'b0;
    end else if (bus.flush) begin
      ctrl_q  <= '0;
      valid_q <= 1'b0;
    end else if (!bus.stall) begin
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
      case (state_q)
        ST_RUN:    if (halt_load) state_q <= ST_HALTED;
        ST_HALTED: state_q <= ST_HALTED;
        default:   state_q <= ST_RUN;
      endcase
      if (err_load) err_q <= 1'b1;
    end
  end

  assign bus.alu_op    = OPW'(ctrl_q.op);
  assign bus.inv_a     = ctrl_q.inv_a;
  assign bus.inv_b     = ctrl_q.inv_b;
  assign bus.alu_cin   = ctrl_q.cin;
  assign bus.bsel_imm  = ctrl_q.bsel_imm;
  assign bus.imm_ext   = WIDTH'(ctrl_q.imm_ext);
  assign bus.set_cond  = ctrl_q.set_cond;
  assign bus.set_en    = ctrl_q.set_en;
  assign bus.valid_out = valid_q;
  assign bus.halted    = (state_q == ST_HALTED);
  assign bus.err       = err_q;

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Scoreboard bench for alu_ctrl_stage: directed scenarios followed by random traffic,
// checked against a table-level reference decoder.
module tb_alu_ctrl_stage;

`ifdef ALU_CTRL_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef struct packed {
    logic [3:0]  op;
    logic        inv_a;
    logic        inv_b;
    logic        cin;
    logic        bsel;
    logic [15:0] imm;
    logic [1:0]  sc;
    logic        se;
    logic        valid;
    logic        halted;
    logic        err;
  } obs_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_ctrl_stage_if #(.WIDTH(16), .OPW(4)) bus ();

  alu_ctrl_stage #(.WIDTH(16), .OPW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   checks = 0;
  int   errors = 0;
  obs_t exp_q[$];
  obs_t cur_m;
  bit   halted_m, err_m;

  function automatic logic [15:0] s5(input logic [15:0] ins);
    return ins[4] ? 16'(int'(ins[4:0]) - 32) : 16'(ins[4:0]);
  endfunction

  function automatic logic [15:0] s8(input logic [15:0] ins);
    return ins[7] ? 16'(int'(ins[7:0]) - 256) : 16'(ins[7:0]);
  endfunction

  // Reference: what the ALU should do for each instruction, in ISA terms
  function automatic obs_t ref_fields(input logic [15:0] ins);
    obs_t e;
    int   opc, fn;
    e   = '0;
    opc = int'(ins[15:11]);
    fn  = int'(ins[1:0]);
    e.valid = 1'b1;
    case (opc)
      8:  begin e.bsel = 1; e.imm = s5(ins); end                              // ADDI
      9:  begin e.bsel = 1; e.imm = s5(ins); e.inv_a = 1; e.cin = 1; end      // SUBI
      10: begin e.bsel = 1; e.imm = 16'(ins[4:0]); e.op = 2; end              // XORI
      11: begin e.bsel = 1; e.imm = 16'(ins[4:0]); e.op = 3; e.inv_b = 1; end // ANDNI
      20, 21, 22, 23: begin e.bsel = 1; e.imm = 16'(ins[3:0]); e.op = 4'(4 + opc - 20); end
      16, 17, 19: begin e.bsel = 1; e.imm = s5(ins); end                      // ST/LD/STU
      27: begin
        if (fn == 1) begin e.inv_a = 1; e.cin = 1; end
        if (fn == 2) e.op = 2;
        if (fn == 3) begin e.op = 3; e.inv_b = 1; end
      end
      26: e.op = 4'(4 + fn);
      28, 29, 30: begin e.inv_b = 1; e.cin = 1; e.se = 1; e.sc = 2'(opc - 28); end
      31: begin e.se = 1; e.sc = 2'd3; end
      25: e.op = 4'd9;
      24: begin e.bsel = 1; e.imm = s8(ins); end
      18: begin e.bsel = 1; e.imm = 16'(ins[7:0]); e.op = 4'd8; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic model_step(input bit r, input logic [15:0] ins, input bit v, st, fl);
    bit unenc;
    unenc = (ins[15:11] == 5'd2) || (ins[15:11] == 5'd3);
    if (r) begin
      cur_m = '0; halted_m = 0; err_m = 0;
    end else if (fl) begin
      cur_m = '0;
    end else if (!st) begin
      if (!v || halted_m) cur_m = '0;
      else if (ERR_EN && unenc) begin cur_m = '0; err_m = 1; end
      else begin
        cur_m = ref_fields(ins);
        if (ins[15:11] == 5'd0) halted_m = 1;
      end
    end
    cur_m.halted = halted_m;
    cur_m.err    = err_m;
  endtask

  task automatic issue(input bit r, input logic [15:0] ins, input bit v, st, fl);
    @(negedge clk);
    rst = r; bus.instr = ins; bus.valid_in = v; bus.stall = st; bus.flush = fl;
    model_step(r, ins, v, st, fl);
    exp_q.push_back(cur_m);
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, want, $time);
    end
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every edge presents a registered bundle; compare against the oldest prediction
  initial begin
    obs_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '{bus.alu_op, bus.inv_a, bus.inv_b, bus.alu_cin, bus.bsel_imm, bus.imm_ext,
              bus.set_cond, bus.set_en, bus.valid_out, bus.halted, bus.err};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL bundle: got %h expected %h at %0t", a, e, $time);
        end
      end
    end
  end

  localparam logic [15:0] I_ADDI_M3  = {5'b01000, 6'd0, 5'b11101};
  localparam logic [15:0] I_SUB_R    = {5'b11011, 9'd0, 2'b01};
  localparam logic [15:0] I_ANDNI_1F = {5'b01011, 6'd0, 5'h1F};
  localparam logic [15:0] I_SLLI_4   = {5'b10101, 7'd0, 4'd4};
  localparam logic [15:0] I_XORI     = {5'b01010, 6'd0, 5'h0A};
  localparam logic [15:0] I_HALT     = 16'h0000;
  localparam logic [15:0] I_ADD_R    = {5'b11011, 11'd0};

  initial begin
    logic [15:0] ins;
    bit r, v, st, fl;
    rst = 1'b1; bus.instr = '0; bus.valid_in = 1'b0; bus.stall = 1'b0; bus.flush = 1'b0;
    cur_m = '0; halted_m = 0; err_m = 0;

    issue(1, 16'hD5A3, 1, 1, 0);
    settle();
    chk("reset_valid", 32'(bus.valid_out), 0);
    chk("reset_imm", 32'(bus.imm_ext), 0);
    issue(0, I_ADDI_M3, 1, 0, 0);
    settle();
    chk("addi_imm", 32'(bus.imm_ext), 32'h0000FFFD);
    chk("addi_bsel", 32'(bus.bsel_imm), 1);
    chk("addi_valid", 32'(bus.valid_out), 1);

    issue(0, I_SUB_R, 1, 0, 0);
    settle();
    chk("sub_inva_cin_bsel", {29'd0, bus.inv_a, bus.alu_cin, bus.bsel_imm}, 32'b110);
    issue(0, I_ANDNI_1F, 1, 0, 0);
    settle();
    chk("andni_invb", 32'(bus.inv_b), 1);
    chk("andni_imm", 32'(bus.imm_ext), 32'h001F);

    issue(0, I_SLLI_4, 1, 0, 0);
    for (int unsigned k = 0; k < 3; k++) issue(0, I_XORI, 1, 1, 0);
    settle();
    chk("stall_hold_op", 32'(bus.alu_op), 32'b0101);
    chk("stall_hold_imm", 32'(bus.imm_ext), 4);

    issue(0, I_XORI, 1, 1, 1);
    settle();
    chk("stall_flush_valid", 32'(bus.valid_out), 0);
    chk("stall_flush_fields", {12'd0, bus.alu_op, bus.imm_ext}, 0);

    issue(0, I_HALT, 1, 0, 1);
    settle();
    chk("flushed_halt_no_halt", 32'(bus.halted), 0);
    issue(0, I_HALT, 1, 0, 0);
    settle();
    chk("halt_sticky_set", 32'(bus.halted), 1);
    issue(0, I_ADD_R, 1, 0, 0);
    settle();
    chk("halted_bubble", 32'(bus.valid_out), 0);
    issue(1, I_ADD_R, 1, 0, 0);
    settle();
    chk("rst_clears_halt", 32'(bus.halted), 0);

`ifdef ALU_CTRL_ERR_EN
    issue(0, {5'b00010, 11'h155}, 1, 0, 0);
    settle();
    chk("err_set", 32'(bus.err), 1);
    chk("err_bubble", 32'(bus.valid_out), 0);
    issue(0, I_ADDI_M3, 1, 0, 0);
    settle();
    chk("err_sticky", 32'(bus.err), 1);
    issue(1, I_ADDI_M3, 1, 0, 0);
`endif

    issue(0, I_ADDI_M3, 0, 0, 0);
    for (int unsigned n = 0; n < 3000; n++) begin
      ins = 16'($urandom);
      if (ins[15:11] == 5'd0 && $urandom_range(0, 3) != 0) ins[15:11] = 5'b01000;
      r  = ($urandom_range(0, 99) == 0);
      v  = ($urandom_range(0, 9) < 8);
      st = ($urandom_range(0, 99) < 15);
      fl = ($urandom_range(0, 99) < 8);
      issue(r, ins, v, st, fl);
    end
    issue(0, 16'h0800, 0, 0, 0);
    issue(0, 16'h0800, 0, 0, 0);
    settle();
    settle();
    chk("queue_drained", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
